mem_responder: RTL and testbench
================================

# mem_responder

Word-addressed synchronous memory responder at the far end of the RISC240 memory bus: it accepts read and write requests issued by the datapath over memAddr, dataBus, re_L and we_L, and inserts a programmable number of wait states. For reads it drives dataBus; for writes it commits the word driven on dataBus. It signals completion on ready so the control path can hold the request until the access finishes.

## Interface
Parameters:
- ADDR_W, 10, word-address bits; the memory holds 2**ADDR_W 16-bit words.
- WAIT_STATES, 2, extra cycles between request acceptance and response; legal range 0..15.

Ports:
- clock  input  1  single clock; all state changes on its rising edge.
- reset  input  1  synchronous, active-high reset.
- memAddr  input  16  byte address; bit 0 ignored; word index = memAddr[ADDR_W:1].
- re_L  input  1  read strobe, active low.
- we_L  input  1  write strobe, active low.
- dataBus  inout  16  shared data bus; the block drives it only during a read response, otherwise hi-Z.
- ready  output  1  access complete; read data valid / write committed.
- protoErr  output  1  one-cycle pulse on an illegal request (re_L and we_L both low).
- busy  output  1  high whenever the FSM is not IDLE.

## Operation
- States: IDLE, WAIT, RESP, HOLD.
- IDLE: if exactly one strobe is low at the clock edge, latch the word index, request type, and (for writes) dataBus. Next state is WAIT, or RESP if WAIT_STATES=0. The wait counter loads WAIT_STATES-1.
- IDLE with both strobes low: stay IDLE, pulse protoErr for the next cycle, accept nothing, do not modify memory.
- WAIT: decrement the counter; when it reaches 0, go to RESP. If the active strobe deasserts, abort: go to IDLE, no write, no drive.
- RESP, read: drive dataBus with mem[latched index]; ready=1.
- RESP, write: write the latched data to mem[latched index] at the edge that leaves RESP; ready=1.
- RESP always goes to HOLD next.
- HOLD: ready stays 1. Read data is still driven, unless the read strobe has deasserted. Go to IDLE at the first edge where both strobes are high.
- Read data comes from the memory array at the latched index. A write committed in RESP is visible to any later read.
- Address and write data are frozen at acceptance. Later changes to memAddr or dataBus do not affect the access.
- Wrap-around: memAddr bits above ADDR_W are ignored, so addresses alias modulo 2**(ADDR_W+1) bytes.
- A strobe of the other type asserted during WAIT, RESP or HOLD is ignored. It is only evaluated in IDLE.

## Timing
- Reset values: state IDLE, ready=0, protoErr=0, busy=0, dataBus hi-Z, counter 0. Memory contents are not cleared.
- Reset mid-access: at the next edge go to IDLE and release the bus. An uncommitted write is dropped; an already committed write persists.
- Latency: request sampled at edge k. ready is high from cycle k+1+WAIT_STATES until the cycle after both strobes are seen high.
- WAIT_STATES=0: ready is high in the cycle immediately after acceptance.
- dataBus enable is combinational from (state in RESP or HOLD) AND read AND re_L low. The bus is therefore released in the same cycle re_L rises.
- Back-to-back accesses: a new request is accepted no earlier than the edge after HOLD exits. Minimum spacing is WAIT_STATES+3 cycles.
- protoErr is registered and lasts exactly one cycle per illegal sampled cycle.

## Test plan
- WAIT_STATES=2. Write 16'hBEEF to memAddr 16'h0010, then read 16'h0010. Required: ready rises 3 cycles after each strobe; read drives 16'hBEEF; bus is hi-Z after re_L rises.
- WAIT_STATES=0. Read address 16'h0004 after preloading 16'h1234. Required: ready and dataBus=16'h1234 one cycle after acceptance.
- Abort: assert we_L with data 16'hAAAA and release it after 1 cycle, with WAIT_STATES=2. Required: ready never rises; a later read of the same address returns the old value.
- Illegal request: re_L=we_L=0 for one cycle in IDLE. Required: protoErr high for exactly one cycle, busy stays 0, memory unchanged.
- Reset mid-WAIT during a write of 16'h5555. Required: next cycle IDLE, ready=0, bus hi-Z; the address still holds its prior contents.
- Alias: ADDR_W=10. Write 16'h0F0F to 16'h0002, then read 16'h0802. Required: returns 16'h0F0F; memAddr bit 0 set on the read (16'h0003) returns the same word.

Source files
------------

// File: rtl/mem_responder.sv
// mem_responder: word-addressed synchronous memory at the far end of the
// RISC240 memory bus. Accepts one read or write request at a time from the
// datapath, inserts WAIT_STATES wait cycles, then completes the access and
// holds ready until both strobes are released.
//
// Parameters:
//   ADDR_W       word-address bits; the array holds 2**ADDR_W 16-bit words
//   WAIT_STATES  cycles between acceptance and response (0..15)
//
// Ports:
//   clock     single clock, rising-edge active
//   reset     synchronous active-high reset
//   memAddr   byte address; word index = memAddr[ADDR_W:1]
//   re_L      read strobe, active low
//   we_L      write strobe, active low
//   dataBus   shared data bus; driven only during a read response
//   ready     access complete (read data valid / write committed)
//   protoErr  one-cycle pulse after an illegal request (both strobes low)
//   busy      high whenever the FSM is not idle

module mem_responder #(
    parameter int unsigned ADDR_W      = 10,
    parameter int unsigned WAIT_STATES = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [15:0] memAddr,
    input  logic        re_L,
    input  logic        we_L,
    inout  logic [15:0] dataBus,
    output logic        ready,
    output logic        protoErr,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP,
        HOLD
    } stateE;

    // Counter start value; with no wait states WAIT is skipped entirely.
    localparam logic [3:0] WAIT_LOAD =
        (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

    stateE              state;
    stateE              nextState;
    logic [3:0]         waitCnt;
    logic [ADDR_W-1:0]  idxQ;
    logic               isReadQ;
    logic [15:0]        wdataQ;
    logic [15:0]        rdData;
    logic               driveEn;
    logic               accept;
    logic               illegal;
    logic               strobeActive;

    logic [15:0]        mem [2**ADDR_W];

    // Address bits outside the word index intentionally do not participate.
    logic               unusedAddrBits;
    assign unusedAddrBits = ^{memAddr[15:ADDR_W+1], memAddr[0]};

    assign accept       = (state == IDLE) && (re_L ^ we_L);
    assign illegal      = (state == IDLE) && !re_L && !we_L;
    // The strobe of the accepted access type; the other strobe is ignored.
    assign strobeActive = isReadQ ? !re_L : !we_L;

    // State register and request latches.
    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= IDLE;
            waitCnt  <= '0;
            protoErr <= 1'b0;
            idxQ     <= '0;
            isReadQ  <= 1'b0;
            wdataQ   <= '0;
        end else begin
            state    <= nextState;
            protoErr <= illegal;
            if (accept) begin
                idxQ    <= memAddr[ADDR_W:1];
                isReadQ <= !re_L;
                wdataQ  <= dataBus;
                waitCnt <= WAIT_LOAD;
            end else if (state == WAIT && waitCnt != 4'd0) begin
                waitCnt <= waitCnt - 4'd1;
            end
        end
    end

    // Next-state logic.
    always_comb begin
        nextState = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    nextState = (WAIT_STATES == 0) ? RESP : WAIT;
                end
            end
            WAIT: begin
                // Abort takes priority over the counter expiring.
                if (!strobeActive) begin
                    nextState = IDLE;
                end else if (waitCnt == 4'd0) begin
                    nextState = RESP;
                end
            end
            RESP: nextState = HOLD;
            HOLD: begin
                if (re_L && we_L) begin
                    nextState = IDLE;
                end
            end
            default: nextState = IDLE;
        endcase
    end

    // Outputs.
    always_comb begin
        ready   = (state == RESP) || (state == HOLD);
        busy    = (state != IDLE);
        driveEn = ready && isReadQ && !re_L;
    end

    // Memory array: not cleared by reset. The write lands on the edge that
    // leaves RESP; a reset on that same edge drops it.
    always_ff @(posedge clock) begin
        if (!reset && state == RESP && !isReadQ) begin
            mem[idxQ] <= wdataQ;
        end
    end

    assign rdData  = mem[idxQ];
    assign dataBus = driveEn ? rdData : 'z;

endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: directed self-checking bench for mem_responder.
// Two instances: dut2 (WAIT_STATES=2) and dut0 (WAIT_STATES=0), both with
// ADDR_W=10, each with its own strobes and tri-state bus.
// A hi-Z check drives 16'h0000 onto the bus from the bench; any DUT driver
// active at that moment makes the bus read something other than 16'h0000.

module tb_mem_responder;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    // WAIT_STATES=2 instance
    logic [15:0] memAddr;
    logic        re_L;
    logic        we_L;
    wire  [15:0] bus2;
    logic [15:0] drv2;
    logic        en2;
    logic        ready2;
    logic        protoErr2;
    logic        busy2;
    assign bus2 = en2 ? drv2 : 'z;

    // WAIT_STATES=0 instance
    logic [15:0] addr0;
    logic        re0;
    logic        we0;
    wire  [15:0] bus0;
    logic [15:0] drv0;
    logic        en0;
    logic        ready0;
    logic        protoErr0;
    logic        busy0;
    assign bus0 = en0 ? drv0 : 'z;

    int nCompared = 0;
    int nMismatch = 0;

    mem_responder #(.ADDR_W(10), .WAIT_STATES(2)) dut2 (
        .clock    (clock),
        .reset    (reset),
        .memAddr  (memAddr),
        .re_L     (re_L),
        .we_L     (we_L),
        .dataBus  (bus2),
        .ready    (ready2),
        .protoErr (protoErr2),
        .busy     (busy2)
    );

    mem_responder #(.ADDR_W(10), .WAIT_STATES(0)) dut0 (
        .clock    (clock),
        .reset    (reset),
        .memAddr  (addr0),
        .re_L     (re0),
        .we_L     (we0),
        .dataBus  (bus0),
        .ready    (ready0),
        .protoErr (protoErr0),
        .busy     (busy0)
    );

    task automatic cyc;
        @(posedge clock);
        #1;
    endtask

    // Stimulus only: full write on dut2 with a bounded wait for ready.
    task automatic write2(input logic [15:0] a, input logic [15:0] d, output bit ok);
        ok      = 1'b0;
        memAddr = a;
        drv2    = d;
        en2     = 1'b1;
        we_L    = 1'b0;
        for (int i = 0; i < 12; i++) begin
            cyc();
            if (ready2 === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        we_L = 1'b1;
        en2  = 1'b0;
        cyc();
        cyc();
    endtask

    // Stimulus only: full read on dut2, returns the bus value seen with ready.
    task automatic read2(input logic [15:0] a, output logic [15:0] d, output bit ok);
        ok      = 1'b0;
        d       = 'x;
        memAddr = a;
        en2     = 1'b0;
        re_L    = 1'b0;
        for (int i = 0; i < 12; i++) begin
            cyc();
            if (ready2 === 1'b1) begin
                d  = bus2;
                ok = 1'b1;
                break;
            end
        end
        re_L = 1'b1;
        cyc();
        cyc();
    endtask

    task automatic test_reset;
        reset = 1'b1;
        re_L = 1'b1; we_L = 1'b1; en2 = 1'b0; drv2 = '0; memAddr = '0;
        re0 = 1'b1; we0 = 1'b1; en0 = 1'b0; drv0 = '0; addr0 = '0;
        cyc();
        cyc();
        nCompared++;
        if (ready2 !== 1'b0) begin nMismatch++; $display("FAIL reset_ready2: got %b expected 0", ready2); end
        nCompared++;
        if (protoErr2 !== 1'b0) begin nMismatch++; $display("FAIL reset_protoErr2: got %b expected 0", protoErr2); end
        nCompared++;
        if (busy2 !== 1'b0) begin nMismatch++; $display("FAIL reset_busy2: got %b expected 0", busy2); end
        nCompared++;
        if (ready0 !== 1'b0 || busy0 !== 1'b0) begin
            nMismatch++; $display("FAIL reset_dut0: got ready=%b busy=%b expected 0/0", ready0, busy0);
        end
        drv2 = 16'h0000; en2 = 1'b1; #1;
        nCompared++;
        if (bus2 !== 16'h0000) begin nMismatch++; $display("FAIL reset_hiz: got %h expected 0000", bus2); end
        en2 = 1'b0;
        reset = 1'b0;
        cyc();
    endtask

    task automatic test_write_read;
        // write BEEF to 0010; ready 3 cycles after the strobe
        memAddr = 16'h0010; drv2 = 16'hBEEF; en2 = 1'b1; we_L = 1'b0;
        for (int j = 1; j <= 3; j++) begin
            cyc();
            nCompared++;
            if (ready2 !== (j == 3)) begin
                nMismatch++; $display("FAIL wr_latency_c%0d: got %b expected %b", j, ready2, (j == 3));
            end
            if (j == 1) begin
                nCompared++;
                if (busy2 !== 1'b1) begin nMismatch++; $display("FAIL wr_busy: got %b expected 1", busy2); end
                // data already latched; later bus changes must not matter
                drv2 = 16'h0000;
            end
        end
        cyc();
        nCompared++;
        if (ready2 !== 1'b1) begin nMismatch++; $display("FAIL wr_hold_ready: got %b expected 1", ready2); end
        we_L = 1'b1; en2 = 1'b0;
        cyc();
        nCompared++;
        if (ready2 !== 1'b0 || busy2 !== 1'b0) begin
            nMismatch++; $display("FAIL wr_exit: got ready=%b busy=%b expected 0/0", ready2, busy2);
        end
        // read 0010 back; address changed after acceptance
        memAddr = 16'h0010; re_L = 1'b0;
        for (int j = 1; j <= 3; j++) begin
            cyc();
            if (j == 1) memAddr = 16'h0000;
            nCompared++;
            if (ready2 !== (j == 3)) begin
                nMismatch++; $display("FAIL rd_latency_c%0d: got %b expected %b", j, ready2, (j == 3));
            end
        end
        nCompared++;
        if (bus2 !== 16'hBEEF) begin nMismatch++; $display("FAIL rd_data_resp: got %h expected BEEF", bus2); end
        cyc();
        nCompared++;
        if (bus2 !== 16'hBEEF || ready2 !== 1'b1) begin
            nMismatch++; $display("FAIL rd_data_hold: got %h ready=%b expected BEEF ready=1", bus2, ready2);
        end
        re_L = 1'b1; #1;
        drv2 = 16'h0000; en2 = 1'b1; #1;
        nCompared++;
        if (bus2 !== 16'h0000) begin nMismatch++; $display("FAIL rd_release_hiz: got %h expected 0000", bus2); end
        en2 = 1'b0;
        cyc();
        nCompared++;
        if (ready2 !== 1'b0) begin nMismatch++; $display("FAIL rd_exit: got %b expected 0", ready2); end
    endtask

    task automatic test_abort;
        logic [15:0] d;
        bit          ok;
        memAddr = 16'h0010; drv2 = 16'hAAAA; en2 = 1'b1; we_L = 1'b0;
        cyc();
        we_L = 1'b1; en2 = 1'b0;
        for (int j = 1; j <= 4; j++) begin
            cyc();
            nCompared++;
            if (ready2 !== 1'b0) begin nMismatch++; $display("FAIL abort_ready_c%0d: got %b expected 0", j, ready2); end
        end
        nCompared++;
        if (busy2 !== 1'b0) begin nMismatch++; $display("FAIL abort_busy: got %b expected 0", busy2); end
        read2(16'h0010, d, ok);
        nCompared++;
        if (!ok || d !== 16'hBEEF) begin nMismatch++; $display("FAIL abort_readback: got %h ok=%0d expected BEEF", d, ok); end
    endtask

    task automatic test_illegal;
        logic [15:0] d;
        bit          ok;
        memAddr = 16'h0010; drv2 = 16'h1111; en2 = 1'b1; re_L = 1'b0; we_L = 1'b0;
        cyc();
        nCompared++;
        if (protoErr2 !== 1'b1) begin nMismatch++; $display("FAIL illegal_pulse: got %b expected 1", protoErr2); end
        nCompared++;
        if (busy2 !== 1'b0) begin nMismatch++; $display("FAIL illegal_busy: got %b expected 0", busy2); end
        re_L = 1'b1; we_L = 1'b1; en2 = 1'b0;
        cyc();
        nCompared++;
        if (protoErr2 !== 1'b0 || busy2 !== 1'b0) begin
            nMismatch++; $display("FAIL illegal_end: got protoErr=%b busy=%b expected 0/0", protoErr2, busy2);
        end
        read2(16'h0010, d, ok);
        nCompared++;
        if (!ok || d !== 16'hBEEF) begin nMismatch++; $display("FAIL illegal_readback: got %h ok=%0d expected BEEF", d, ok); end
    endtask

    task automatic test_reset_mid;
        logic [15:0] d;
        bit          ok;
        memAddr = 16'h0010; drv2 = 16'h5555; en2 = 1'b1; we_L = 1'b0;
        cyc();
        nCompared++;
        if (busy2 !== 1'b1) begin nMismatch++; $display("FAIL rstmid_wait: got busy=%b expected 1", busy2); end
        reset = 1'b1;
        cyc();
        nCompared++;
        if (busy2 !== 1'b0 || ready2 !== 1'b0) begin
            nMismatch++; $display("FAIL rstmid_idle: got busy=%b ready=%b expected 0/0", busy2, ready2);
        end
        reset = 1'b0; we_L = 1'b1;
        drv2 = 16'h0000; #1;
        nCompared++;
        if (bus2 !== 16'h0000) begin nMismatch++; $display("FAIL rstmid_hiz: got %h expected 0000", bus2); end
        en2 = 1'b0;
        cyc();
        read2(16'h0010, d, ok);
        nCompared++;
        if (!ok || d !== 16'hBEEF) begin nMismatch++; $display("FAIL rstmid_readback: got %h ok=%0d expected BEEF", d, ok); end
    endtask

    task automatic test_alias;
        logic [15:0] d;
        bit          ok;
        write2(16'h0002, 16'h0F0F, ok);
        nCompared++;
        if (!ok) begin nMismatch++; $display("FAIL alias_write: got no ready expected ready"); end
        read2(16'h0802, d, ok);
        nCompared++;
        if (!ok || d !== 16'h0F0F) begin nMismatch++; $display("FAIL alias_0802: got %h ok=%0d expected 0F0F", d, ok); end
        read2(16'h0003, d, ok);
        nCompared++;
        if (!ok || d !== 16'h0F0F) begin nMismatch++; $display("FAIL alias_0003: got %h ok=%0d expected 0F0F", d, ok); end
    endtask

    task automatic test_cross_strobe;
        // write strobe asserted mid-read must be ignored
        memAddr = 16'h0010; re_L = 1'b0;
        cyc();
        we_L = 1'b0;
        cyc();
        nCompared++;
        if (protoErr2 !== 1'b0 || ready2 !== 1'b0) begin
            nMismatch++; $display("FAIL cross_wait: got protoErr=%b ready=%b expected 0/0", protoErr2, ready2);
        end
        cyc();
        nCompared++;
        if (ready2 !== 1'b1 || bus2 !== 16'hBEEF) begin
            nMismatch++; $display("FAIL cross_resp: got ready=%b bus=%h expected 1/BEEF", ready2, bus2);
        end
        re_L = 1'b1; we_L = 1'b1;
        cyc();
        cyc();
        nCompared++;
        if (busy2 !== 1'b0 || protoErr2 !== 1'b0) begin
            nMismatch++; $display("FAIL cross_exit: got busy=%b protoErr=%b expected 0/0", busy2, protoErr2);
        end
    endtask

    task automatic test_zero_wait;
        addr0 = 16'h0004; drv0 = 16'h1234; en0 = 1'b1; we0 = 1'b0;
        cyc();
        nCompared++;
        if (ready0 !== 1'b1) begin nMismatch++; $display("FAIL zw_write_ready: got %b expected 1", ready0); end
        cyc();
        we0 = 1'b1; en0 = 1'b0;
        cyc();
        nCompared++;
        if (ready0 !== 1'b0) begin nMismatch++; $display("FAIL zw_write_exit: got %b expected 0", ready0); end
        re0 = 1'b0;
        cyc();
        nCompared++;
        if (ready0 !== 1'b1) begin nMismatch++; $display("FAIL zw_read_ready: got %b expected 1", ready0); end
        nCompared++;
        if (bus0 !== 16'h1234) begin nMismatch++; $display("FAIL zw_read_data: got %h expected 1234", bus0); end
        re0 = 1'b1;
        cyc();
        cyc();
        nCompared++;
        if (busy0 !== 1'b0) begin nMismatch++; $display("FAIL zw_exit: got %b expected 0", busy0); end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_abort();
        test_illegal();
        test_reset_mid();
        test_alias();
        test_cross_strobe();
        test_zero_wait();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
        $finish;
    end

endmodule
